// File: rtl/timer_alarm.sv
// Deadline alarm on top of a free-running ns timer: arms with a relative deadline,
// clears the timer, then raises a sticky interrupt when the deadline or an overflow is seen.
//
// state | meaning
// IDLE  | disarmed, accepts a new configuration
// CLEAR | timer clear requested; ns_cnt_i is stale, no compare this cycle
// ARMED | comparing ns_cnt_i against the latched deadline
module timer_alarm #(
    parameter int NS_CNT_WIDTH = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NS_CNT_WIDTH-1:0] ns_cnt_i,
    input  logic                    overflow_was_i,
    output logic                    to_clear_timer_o,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [NS_CNT_WIDTH-1:0] cfg_deadline_i,
    input  logic                    cfg_periodic_i,
    input  logic                    cancel_i,
    output logic                    irq_o,
    input  logic                    irq_ack_i,
    output logic [7:0]              miss_cnt_o,
    output logic                    busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_ARMED = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [NS_CNT_WIDTH-1:0] deadline_q, deadline_d;
    logic                    periodic_q, periodic_d;
    logic                    irq_q, irq_d;
    logic [7:0]              miss_q, miss_d;
    logic                    fire;

    // Cancel wins over a same-cycle fire, so it is folded into the fire qualifier.
    assign fire = (state_q == S_ARMED) && !cancel_i &&
                  ((ns_cnt_i >= deadline_q) || overflow_was_i);

    always_comb begin
        state_d    = state_q;
        deadline_d = deadline_q;
        periodic_d = periodic_q;
        miss_d     = miss_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid_i) begin
                    state_d    = S_CLEAR;
                    deadline_d = cfg_deadline_i;
                    periodic_d = cfg_periodic_i;
                    miss_d     = 8'd0;
                end
            end
            S_CLEAR: begin
                state_d = cancel_i ? S_IDLE : S_ARMED;
            end
            S_ARMED: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else if (fire) begin
                    state_d = periodic_q ? S_CLEAR : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fire && irq_q && !irq_ack_i && (miss_q != 8'hff)) begin
            miss_d = miss_q + 8'd1;
        end

        irq_d = irq_q;
        if (fire) begin
            irq_d = 1'b1;
        end else if (irq_ack_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            deadline_q <= '0;
            periodic_q <= 1'b0;
            irq_q      <= 1'b0;
            miss_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            deadline_q <= deadline_d;
            periodic_q <= periodic_d;
            irq_q      <= irq_d;
            miss_q     <= miss_d;
        end
    end

    assign to_clear_timer_o = (state_q == S_CLEAR);
    assign cfg_ready_o      = (state_q == S_IDLE);
    assign busy_o           = (state_q != S_IDLE);
    assign irq_o            = irq_q;
    assign miss_cnt_o       = miss_q;

endmodule

// File: tb/tb_timer_alarm.sv
// Bench for timer_alarm: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the alarm rules.
module tb_timer_alarm;

    localparam int W = 30;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] ns_cnt_i = '0;
    logic         overflow_was_i = 1'b0;
    logic         to_clear_timer_o;
    logic         cfg_valid_i = 1'b0;
    logic         cfg_ready_o;
    logic [W-1:0] cfg_deadline_i = '0;
    logic         cfg_periodic_i = 1'b0;
    logic         cancel_i = 1'b0;
    logic         irq_o;
    logic         irq_ack_i = 1'b0;
    logic [7:0]   miss_cnt_o;
    logic         busy_o;

    timer_alarm #(.NS_CNT_WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ns_cnt_i         (ns_cnt_i),
        .overflow_was_i   (overflow_was_i),
        .to_clear_timer_o (to_clear_timer_o),
        .cfg_valid_i      (cfg_valid_i),
        .cfg_ready_o      (cfg_ready_o),
        .cfg_deadline_i   (cfg_deadline_i),
        .cfg_periodic_i   (cfg_periodic_i),
        .cancel_i         (cancel_i),
        .irq_o            (irq_o),
        .irq_ack_i        (irq_ack_i),
        .miss_cnt_o       (miss_cnt_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: busy = armed or clearing, clr = the one timer-clear cycle
    bit         m_busy = 0;
    bit         m_clr  = 0;
    bit         m_irq  = 0;
    int         m_miss = 0;
    bit [W-1:0] m_dl   = '0;
    bit         m_per  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_step();
        bit hit;
        if (rst) begin
            m_busy = 0; m_clr = 0; m_irq = 0; m_miss = 0; m_dl = '0; m_per = 0;
        end else if (!m_busy) begin
            if (irq_ack_i) m_irq = 0;
            if (cfg_valid_i) begin
                m_busy = 1; m_clr = 1; m_dl = cfg_deadline_i; m_per = cfg_periodic_i; m_miss = 0;
            end
        end else if (cancel_i) begin
            m_busy = 0; m_clr = 0;
            if (irq_ack_i) m_irq = 0;
        end else if (m_clr) begin
            m_clr = 0;
            if (irq_ack_i) m_irq = 0;
        end else begin
            hit = (ns_cnt_i >= m_dl) || overflow_was_i;
            if (hit) begin
                if (m_irq && !irq_ack_i && m_miss < 255) m_miss++;
                m_irq = 1;
                if (m_per) m_clr = 1;
                else m_busy = 0;
            end else if (irq_ack_i) begin
                m_irq = 0;
            end
        end
    endtask

    // one clock: model advances on current inputs, timer reacts to the clear request
    task automatic cyc();
        bit clr_req;
        clr_req = (to_clear_timer_o === 1'b1);
        model_step();
        @(posedge clk);
        #1;
        ns_cnt_i = clr_req ? '0 : ns_cnt_i + W'(20);
        chk("irq",   {31'd0, irq_o},            {31'd0, m_irq});
        chk("miss",  {24'd0, miss_cnt_o},       m_miss);
        chk("busy",  {31'd0, busy_o},           {31'd0, m_busy});
        chk("ready", {31'd0, cfg_ready_o},      {31'd0, !m_busy});
        chk("clr",   {31'd0, to_clear_timer_o}, {31'd0, m_clr});
    endtask

    task automatic arm(input logic [W-1:0] dl, input logic per);
        cfg_valid_i = 1; cfg_deadline_i = dl; cfg_periodic_i = per;
        cyc();
        cfg_valid_i = 0;
    endtask

    task automatic ack_now();
        irq_ack_i = 1; cyc(); irq_ack_i = 0;
    endtask

    task automatic cancel_now();
        cancel_i = 1; cyc(); cancel_i = 0;
    endtask

    initial begin
        int lat;
        #1;
        rst = 1; cyc(); rst = 0;
        chk("rst_ready", {31'd0, cfg_ready_o}, 32'd1);
        chk("rst_busy",  {31'd0, busy_o},      32'd0);

        // one-shot, deadline 100: CLEAR + 6 ARMED cycles -> irq
        arm(30'd100, 1'b0);
        chk("os_clear", {31'd0, to_clear_timer_o}, 32'd1);
        lat = 0;
        while (irq_o !== 1'b1 && lat < 20) begin cyc(); lat++; end
        chk("os_latency", lat, 7);
        chk("os_ready", {31'd0, cfg_ready_o}, 32'd1);
        ack_now();
        chk("os_ack", {31'd0, irq_o}, 32'd0);

        // periodic 60, no ack: a fire every 5 cycles, miss counts up
        arm(30'd60, 1'b1);
        repeat (5) cyc();
        chk("per_first", {31'd0, irq_o}, 32'd1);
        chk("per_miss0", {24'd0, miss_cnt_o}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            repeat (4) cyc();
            chk("per_pre", {24'd0, miss_cnt_o}, k - 1);
            cyc();
            chk("per_missk", {24'd0, miss_cnt_o}, k);
        end
        cancel_now();
        ack_now();

        // fire coinciding with ack keeps irq and miss, lone ack then clears
        arm(30'd60, 1'b1);
        repeat (5) cyc();
        repeat (4) cyc();
        ack_now();
        chk("coin_irq",  {31'd0, irq_o},      32'd1);
        chk("coin_miss", {24'd0, miss_cnt_o}, 32'd0);
        ack_now();
        chk("lone_ack", {31'd0, irq_o}, 32'd0);
        cancel_now();

        // cancel on the fire cycle suppresses the fire
        arm(30'd60, 1'b0);
        repeat (4) cyc();
        cancel_now();
        chk("cxl_irq",  {31'd0, irq_o},  32'd0);
        chk("cxl_busy", {31'd0, busy_o}, 32'd0);

        // overflow forces a fire despite a maximal deadline
        arm(30'h3fff_ffff, 1'b0);
        repeat (3) cyc();
        chk("ovf_pre", {31'd0, irq_o}, 32'd0);
        overflow_was_i = 1; cyc(); overflow_was_i = 0;
        chk("ovf_irq", {31'd0, irq_o}, 32'd1);
        ack_now();

        // periodic deadline 0 saturates miss, then reset beats everything
        arm(30'd0, 1'b1);
        repeat (600) cyc();
        chk("sat_miss", {24'd0, miss_cnt_o}, 32'd255);
        rst = 1; cfg_valid_i = 1; irq_ack_i = 1; cancel_i = 1;
        cyc();
        rst = 0; cfg_valid_i = 0; irq_ack_i = 0; cancel_i = 0;
        chk("rst2_irq",   {31'd0, irq_o},            32'd0);
        chk("rst2_miss",  {24'd0, miss_cnt_o},       32'd0);
        chk("rst2_clr",   {31'd0, to_clear_timer_o}, 32'd0);
        chk("rst2_ready", {31'd0, cfg_ready_o},      32'd1);
        chk("rst2_busy",  {31'd0, busy_o},           32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cfg_valid_i    = ($urandom_range(0, 99) < 30);
            cfg_deadline_i = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 160));
            cfg_periodic_i = $urandom_range(0, 1);
            cancel_i       = ($urandom_range(0, 99) < 5);
            irq_ack_i      = ($urandom_range(0, 99) < 20);
            overflow_was_i = ($urandom_range(0, 99) < 3);
            rst            = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 0; cfg_valid_i = 0; cancel_i = 0; irq_ack_i = 0; overflow_was_i = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/timer_alarm.md
TIMER_ALARM -- requirements
Module: timer_alarm

Interface
REQ-001 SHALL have parameter NS_CNT_WIDTH, default 30: width of the nanosecond count input and the deadline.
REQ-002 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-004 SHALL have port ns_cnt_i  input  NS_CNT_WIDTH: ns elapsed, from the hardware timer.
REQ-005 SHALL have port overflow_was_i  input  1: sticky timer-overflow flag.
REQ-006 SHALL have port to_clear_timer_o  output  1: timer clear request; the timer reads 0 on the cycle after assertion.
REQ-007 SHALL have port cfg_valid_i  input  1: arm request.
REQ-008 SHALL have port cfg_ready_o  output  1: block can accept an arm request.
REQ-009 SHALL have port cfg_deadline_i  input  NS_CNT_WIDTH: relative deadline in ns.
REQ-010 SHALL have port cfg_periodic_i  input  1: 1 = periodic, 0 = one-shot.
REQ-011 SHALL have port cancel_i  input  1: disarm request.
REQ-012 SHALL have port irq_o  output  1: sticky alarm interrupt.
REQ-013 SHALL have port irq_ack_i  input  1: interrupt acknowledge.
REQ-014 SHALL have port miss_cnt_o  output  8: count of fires while irq_o was already pending.
REQ-015 SHALL have port busy_o  output  1: armed (state not IDLE).

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, ARMED.
REQ-017 SHALL drive cfg_ready_o = (state==IDLE) and busy_o = (state!=IDLE), both decoded from state only.
REQ-018 SHALL accept an arm when cfg_valid_i && cfg_ready_o: latch deadline and periodic, clear miss_cnt_o to 0, go to CLEAR.
REQ-019 SHALL assert to_clear_timer_o exactly while state==CLEAR; CLEAR lasts one cycle, then ARMED.
REQ-020 SHALL perform no deadline comparison in CLEAR, because ns_cnt_i is stale in that cycle.
REQ-021 SHALL, in ARMED, detect a fire when ns_cnt_i >= latched deadline (unsigned, full width) or overflow_was_i==1.
REQ-022 SHALL, on a fire, set irq_o on the next edge; a periodic fire goes to CLEAR and a one-shot fire goes to IDLE.
REQ-023 SHALL keep irq_o high until irq_ack_i is sampled high with no fire in the same cycle.
REQ-024 SHALL keep irq_o = 1 when a fire and irq_ack_i coincide, and SHALL NOT increment miss_cnt_o in that case.
REQ-025 SHALL increment miss_cnt_o on a fire when irq_o==1 and irq_ack_i==0, saturating at 255.
REQ-026 SHALL, on cancel_i in CLEAR or ARMED, go to IDLE next cycle, leaving irq_o and miss_cnt_o unchanged.
REQ-027 SHALL give cancel_i priority over a same-cycle fire: no irq, no miss increment.
REQ-028 SHALL ignore cancel_i in IDLE; cfg_valid_i with cancel_i in IDLE SHALL still be accepted.
REQ-029 SHALL treat deadline 0 as legal: fire on the first ARMED cycle; periodic with deadline 0 fires every 2 cycles.
REQ-030 SHALL give fire latency of 1 cycle from the ARMED cycle satisfying REQ-021 to irq_o high.
REQ-031 SHALL ignore cfg_valid_i while busy; a new configuration requires cancel or one-shot completion.

Reset
REQ-032 SHALL, with rst high on an edge, go to IDLE and set irq_o=0, to_clear_timer_o=0, miss_cnt_o=0, and clear the latched deadline/periodic to 0.
REQ-033 SHALL, after reset, have cfg_ready_o=1 and busy_o=0; reset mid-operation aborts any arm with no pending irq.
REQ-034 SHALL give rst priority over all other inputs, including simultaneous cfg_valid_i, irq_ack_i and cancel_i.

Verification
Bench timer model: ns_cnt_i += 20 per cycle; ns_cnt_i reads 0 on the cycle after to_clear_timer_o.
REQ-035 SHALL cover one-shot: arm deadline=100 -> to_clear_timer_o 1 cycle; ns_cnt_i 0..100 over 6 ARMED cycles; irq_o high next cycle; state IDLE, cfg_ready_o=1.
REQ-036 SHALL cover periodic: deadline=60, no ack -> irq_o every 5 cycles (CLEAR + 4 ARMED); miss_cnt_o 0,1,2,... after successive fires.
REQ-037 SHALL cover fire with simultaneous irq_ack_i -> irq_o stays 1, miss_cnt_o unchanged; lone ack next cycle -> irq_o 0.
REQ-038 SHALL cover cancel: cancel_i in the same cycle as the fire condition -> no irq, IDLE next cycle, busy_o=0.
REQ-039 SHALL cover overflow: force overflow_was_i=1 while ARMED with deadline=2^30-1 -> irq_o high next cycle.
REQ-040 SHALL cover miss saturation and reset: periodic deadline=0, no ack, 600 cycles -> miss_cnt_o=255; assert rst -> all outputs at reset values, cfg_ready_o=1.
